mat_result_collector: RTL and testbench
=======================================

MAT_RESULT_COLLECTOR -- requirements
Module: mat_result_collector

Interface
REQ-001 The block SHALL have parameter ELEMS, default 9, giving the number of result words per matrix.
REQ-002 The block SHALL have parameter RW, default 18, giving the result word width.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port start SHALL be an input, 1 bit: clear and arm the collection of one result matrix.
REQ-006 Port byte_in SHALL be an input, 8 bits: byte-serialized result data, LSB byte first.
REQ-007 Port byte_valid SHALL be an input, 1 bit: byte_in holds a byte.
REQ-008 Port byte_ready SHALL be an output, 1 bit: the block accepts a byte this cycle.
REQ-009 Port rd_addr SHALL be an input, 4 bits: buffer read address, 0..ELEMS-1.
REQ-010 Port rd_data SHALL be an output, RW bits: registered buffer read data.
REQ-011 Port busy SHALL be an output, 1 bit: collection in progress.
REQ-012 Port done SHALL be an output, 1 bit: all ELEMS words received.
REQ-013 Port err SHALL be an output, 1 bit: sticky range error (see Configuration).

Function
REQ-014 The FSM SHALL have three states: IDLE, RECV and DONE.
REQ-015 Transitions SHALL be: IDLE -start-> RECV; RECV -last byte of element ELEMS-1 accepted-> DONE; DONE -start-> RECV.
REQ-016 byte_ready SHALL be 1 only in RECV, decoded from registered state only.
REQ-017 A byte SHALL be accepted on a cycle with byte_valid=1 and byte_ready=1; bytes in IDLE or DONE are ignored.
REQ-018 A 2-bit lane counter SHALL cycle 0,1,2,0 on each accepted byte.
- lane 0 -> word[7:0]
- lane 1 -> word[15:8]
- lane 2 -> word[17:16] from byte_in[1:0]
REQ-019 On lane-2 acceptance, the assembled word SHALL be written to buffer[elem], and elem (0..ELEMS-1) SHALL increment.
REQ-020 After element ELEMS-1 is written, elem and lane SHALL return to 0 and the state SHALL enter DONE on the same edge.
REQ-021 Total bytes per matrix SHALL be 3*ELEMS (27 at default).
REQ-022 busy SHALL equal (state==RECV); done SHALL equal (state==DONE), holding until start or reset.
REQ-023 start in RECV SHALL restart collection: lane=0, elem=0, partial word discarded, buffer contents kept.
REQ-024 If start coincides with a byte handshake, start SHALL win and the byte SHALL be discarded.
REQ-025 rd_data SHALL update one cycle after rd_addr is presented.
REQ-026 A read of the address being written in the same cycle SHALL return the old contents.
REQ-027 rd_addr >= ELEMS SHALL return zero.
REQ-028 Reads SHALL be legal in every state.

Reset
REQ-029 Reset SHALL force state=IDLE, lane=0, elem=0, byte_ready=0, busy=0, done=0, err=0 and rd_data=0.
REQ-030 Reset SHALL NOT clear buffer contents; they are undefined until first written.
REQ-031 Reset asserted mid-collection SHALL abort it; no partial word is written.

Configuration
REQ-032 The macro MAT_COLLECT_RANGE_CHK_EN SHALL control range checking.
REQ-033 With MAT_COLLECT_RANGE_CHK_EN defined, an accepted lane-2 byte with byte_in[7:2]!=0 SHALL set err on the next edge.
REQ-034 err SHALL stay set until start or reset, and the word SHALL still be stored using byte_in[1:0].
REQ-035 Without MAT_COLLECT_RANGE_CHK_EN, err SHALL be tied to 0 and no check logic SHALL be generated.

Structure
REQ-036 A shared package SHALL hold the FSM state enum (IDLE, RECV, DONE), the lane index constants (LANE_LO=0, LANE_MID=1, LANE_HI=2) and the defaults ELEMS=9 and RW=18.
REQ-037 The buffer SHALL be one sub-module, result_buffer: ELEMS x RW, one synchronous write port, one registered read port.
REQ-038 The FSM, counters and assembler SHALL reside in the top level.

Verification
REQ-039 Reset, then start, then 27 bytes streamed with valid held high, words i = 0x10000+i*0x101 -> busy for 27 cycles, then done=1, and reading addresses 0..8 returns 0x10000,0x10101,...,0x10808 one cycle later.
REQ-040 Bytes streamed with byte_valid toggled 1,0,1,0 -> only handshake cycles advance; all 9 words are correct and done asserts after the 27th accepted byte.
REQ-041 start after 14 bytes, then a full 27-byte matrix of 0x3FFFF words -> all words read 0x3FFFF and the earlier partial word is not present.
REQ-042 byte_valid=1 in IDLE and in DONE -> byte_ready=0 and the buffer is unchanged; start coincident with a valid byte in RECV -> byte dropped and lane=0.
REQ-043 With MAT_COLLECT_RANGE_CHK_EN, lane-2 byte 0x05 -> err=1 next cycle and the stored bits [17:16]=01; err clears on start; without the macro, err stays 0.
REQ-044 rst pulsed low after 10 bytes -> all outputs reset immediately (asynchronously); a following start plus 27 bytes completes normally.

Source files
------------

// File: rtl/mat_result_collector_pkg.sv
// Shared types and constants for the result collector: FSM states,
// byte-lane indices within one result word, and default geometry.
package mat_result_collector_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte position inside one result word (LSB byte first on the wire)
    localparam logic [1:0] LANE_LO  = 2'd0;
    localparam logic [1:0] LANE_MID = 2'd1;
    localparam logic [1:0] LANE_HI  = 2'd2;

    localparam int DEF_ELEMS = 9;
    localparam int DEF_RW    = 18;
    localparam int ADDR_W    = 4;

endpackage

// File: rtl/mat_result_collector_result_buffer.sv
// result_buffer: ELEMS x RW storage, one synchronous write port and one
// registered read port. A same-cycle read of the address being written
// returns the old contents; out-of-range reads return zero. The storage
// itself is not reset, only the read register.
module result_buffer
    import mat_result_collector_pkg::*;
#(
    parameter int ELEMS = DEF_ELEMS,
    parameter int RW    = DEF_RW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RW-1:0]     wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RW-1:0]     rd_data
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(ELEMS);

    logic [RW-1:0] mem [ELEMS];

    // Write port; address is always < ELEMS because the element counter wraps
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    // Registered read with zero for addresses beyond the matrix
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        rd_data <= '0;
        else if ({1'b0, rd_addr} < DEPTH) rd_data <= mem[rd_addr];
        else                             rd_data <= '0;
    end

endmodule

// File: rtl/mat_result_collector.sv
// mat_result_collector: gathers one matrix of ELEMS result words arriving
// as 3 bytes each (LSB first) and stores them in a readable buffer.
// Optional macro MAT_COLLECT_RANGE_CHK_EN adds a sticky error flag for
// nonzero spare bits in the top byte of a word.
module mat_result_collector
    import mat_result_collector_pkg::*;
#(
    parameter int ELEMS = DEF_ELEMS,
    parameter int RW    = DEF_RW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [RW-1:0]     rd_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(ELEMS - 1);

    state_t            state, state_nxt;
    logic [1:0]        lane;
    logic [ADDR_W-1:0] elem;
    logic [15:0]       word_lo;
    logic              accept;
    logic              wr_en;
    logic [RW-1:0]     wr_data;

    assign byte_ready = (state == RECV);
    assign busy       = (state == RECV);
    assign done       = (state == DONE);

    // start takes priority over a coincident handshake, dropping that byte
    assign accept  = byte_valid && byte_ready && !start;
    assign wr_en   = accept && (lane == LANE_HI);
    assign wr_data = {byte_in[RW-17:0], word_lo};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RECV;
            RECV: begin
                if (start)                                state_nxt = RECV;
                else if (wr_en && (elem == LAST_ELEM))    state_nxt = DONE;
            end
            DONE: if (start) state_nxt = RECV;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane/element counters and partial-word assembly
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane    <= LANE_LO;
            elem    <= '0;
            word_lo <= '0;
        end else if (start) begin
            lane <= LANE_LO;
            elem <= '0;
        end else if (accept) begin
            case (lane)
                LANE_LO: begin
                    word_lo[7:0] <= byte_in;
                    lane         <= LANE_MID;
                end
                LANE_MID: begin
                    word_lo[15:8] <= byte_in;
                    lane          <= LANE_HI;
                end
                default: begin
                    lane <= LANE_LO;
                    elem <= (elem == LAST_ELEM) ? '0 : elem + 1'b1;
                end
            endcase
        end
    end

`ifdef MAT_COLLECT_RANGE_CHK_EN
    logic err_q;

    // Sticky flag for spare top-byte bits; word is still stored truncated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                err_q <= 1'b0;
        else if (start)                          err_q <= 1'b0;
        else if (wr_en && (byte_in[7:RW-16] != '0)) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    logic unused_hi_bits;
    assign unused_hi_bits = ^byte_in[7:RW-16];
    assign err = 1'b0;
`endif

    result_buffer #(
        .ELEMS (ELEMS),
        .RW    (RW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (elem),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_mat_result_collector.sv
// Directed bench for mat_result_collector: reset, streaming, throttled
// streaming, restart, ignored bytes, range flag and mid-collection reset.
module tb_mat_result_collector;

`ifdef MAT_COLLECT_RANGE_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic [3:0]  rd_addr = 4'd0;
    logic [17:0] rd_data;
    logic        busy, done, err;

    int n_chk  = 0;
    int n_fail = 0;

    mat_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1; byte_in = b; tick(); byte_valid = 1'b0;
    endtask

    function automatic logic [7:0] byte_of(input logic [17:0] w, input int k);
        if (k == 0)      return w[7:0];
        else if (k == 1) return w[15:8];
        else             return {6'b0, w[17:16]};
    endfunction

    task automatic send_word(input logic [17:0] w);
        for (int k = 0; k < 3; k++) send_byte(byte_of(w, k));
    endtask

    task automatic rd(input logic [3:0] a, output logic [17:0] d);
        rd_addr = a; tick(); d = rd_data;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_chk++; if (rd_data !== 18'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        rst = 1'b1; tick();
    endtask

    task automatic test_stream();
        logic [17:0] w, d;
        int busy_cnt = 0;
        do_start();
        for (int i = 0; i < 9; i++) begin
            w = 18'h10000 + 18'(i * 18'h101);
            for (int k = 0; k < 3; k++) begin
                if (busy === 1'b1 && byte_ready === 1'b1) busy_cnt++;
                send_byte(byte_of(w, k));
            end
        end
        n_chk++; if (busy_cnt != 27) begin n_fail++; $display("FAIL stream_busy_cycles: got %0d want 27", busy_cnt); end
        n_chk++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL stream_done: got done=%b busy=%b want done=1 busy=0", done, busy); end
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), d);
            w = 18'h10000 + 18'(i * 18'h101);
            n_chk++; if (d !== w) begin n_fail++; $display("FAIL stream_word%0d: got %h want %h", i, d, w); end
        end
        rd(4'd9, d);
        n_chk++; if (d !== 18'h0) begin n_fail++; $display("FAIL rd_oob9: got %h want 0", d); end
        rd(4'd15, d);
        n_chk++; if (d !== 18'h0) begin n_fail++; $display("FAIL rd_oob15: got %h want 0", d); end
    endtask

    task automatic test_toggle();
        logic [17:0] w, d;
        do_start();
        for (int n = 0; n < 27; n++) begin
            w = 18'(n / 3 * 18'h3333) + 18'h5;
            if (n == 26) begin
                n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL toggle_early_done: got %b want 0", done); end
            end
            send_byte(byte_of(w, n % 3));
            byte_in = 8'hEE; tick();
        end
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL toggle_done: got %b want 1", done); end
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), d);
            w = 18'(i * 18'h3333) + 18'h5;
            n_chk++; if (d !== w) begin n_fail++; $display("FAIL toggle_word%0d: got %h want %h", i, d, w); end
        end
    endtask

    task automatic test_restart();
        logic [17:0] d;
        do_start();
        for (int n = 0; n < 14; n++) send_byte(8'h00);
        do_start();
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b want 1", busy); end
        for (int i = 0; i < 9; i++) send_word(18'h3FFFF);
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", done); end
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), d);
            n_chk++; if (d !== 18'h3FFFF) begin n_fail++; $display("FAIL restart_word%0d: got %h want 3ffff", i, d); end
        end
    endtask

    task automatic test_ignore();
        logic [17:0] d;
        // DONE: bytes offered must be refused
        for (int n = 0; n < 4; n++) begin
            byte_valid = 1'b1; byte_in = 8'h00;
            n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL done_ready: got %b want 0", byte_ready); end
            tick();
        end
        byte_valid = 1'b0;
        rd(4'd0, d);
        n_chk++; if (d !== 18'h3FFFF) begin n_fail++; $display("FAIL done_buf_kept: got %h want 3ffff", d); end
        // RECV: start plus a valid byte on the same edge drops the byte
        do_start();
        start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA; tick();
        start = 1'b0; byte_valid = 1'b0;
        send_word(18'h12345);
        rd(4'd0, d);
        n_chk++; if (d !== 18'h12345) begin n_fail++; $display("FAIL start_drop_byte: got %h want 12345", d); end
        rd(4'd1, d);
        n_chk++; if (d !== 18'h3FFFF) begin n_fail++; $display("FAIL start_buf_kept: got %h want 3ffff", d); end
    endtask

    task automatic test_range_err();
        logic [17:0] d;
        do_start();
        send_byte(8'h00); send_byte(8'h00);
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_before: got %b want 0", err); end
        send_byte(8'h05);
        n_chk++; if (err !== CHK) begin n_fail++; $display("FAIL err_set: got %b want %b", err, CHK); end
        send_word(18'h00001);
        n_chk++; if (err !== CHK) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err, CHK); end
        rd(4'd0, d);
        n_chk++; if (d !== 18'h10000) begin n_fail++; $display("FAIL err_word_trunc: got %h want 10000", d); end
        do_start();
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear_on_start: got %b want 0", err); end
    endtask

    task automatic test_abort();
        logic [17:0] d, w;
        do_start();
        for (int n = 0; n < 10; n++) send_byte(byte_of(18'h1ABCD + 18'(n / 3), n % 3));
        #2 rst = 1'b0; #1;
        n_chk++; if (busy !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
            n_fail++; $display("FAIL abort_ctrl: got busy=%b ready=%b done=%b err=%b want all 0", busy, byte_ready, done, err); end
        n_chk++; if (rd_data !== 18'h0) begin n_fail++; $display("FAIL abort_rd_data: got %h want 0", rd_data); end
        tick(); rst = 1'b1; tick();
        // IDLE: offered bytes refused, buffer untouched
        for (int n = 0; n < 3; n++) begin
            byte_valid = 1'b1; byte_in = 8'h77;
            n_chk++; if (byte_ready !== 1'b0) begin n_fail++; $display("FAIL idle_ready: got %b want 0", byte_ready); end
            tick();
        end
        byte_valid = 1'b0;
        rd(4'd2, d);
        n_chk++; if (d !== 18'h1ABCF) begin n_fail++; $display("FAIL idle_buf_kept: got %h want 1abcf", d); end
        do_start();
        for (int i = 0; i < 9; i++) send_word(18'(i * 18'h4321));
        n_chk++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_recover_done: got %b want 1", done); end
        for (int i = 0; i < 9; i++) begin
            rd(4'(i), d);
            w = 18'(i * 18'h4321);
            n_chk++; if (d !== w) begin n_fail++; $display("FAIL abort_word%0d: got %h want %h", i, d, w); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_restart();
        test_ignore();
        test_range_err();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
